// File: rtl/ushift_param.sv
// Universal shift register: shift/rotate in both directions, parallel load, clear,
// and a shared shift counter that strobes done once every SIZE counted operations.
module ushift_param #(
  parameter int              SIZE    = 512,
  parameter logic [SIZE-1:0] RST_VAL = '0,
  localparam int             CNTW    = $clog2(SIZE + 1)
) (
  input  logic            ushift_param_cport_clk,
  input  logic            ushift_param_cport_rst,
  input  logic            ushift_param_cport_en,
  input  logic [2:0]      ushift_param_cport_mode,
  input  logic            ushift_param_iport_sil,
  input  logic            ushift_param_iport_sir,
  input  logic [SIZE-1:0] ushift_param_ipport_pi,
  output logic [SIZE-1:0] ushift_param_oport_p,
  output logic            ushift_param_oport_sol,
  output logic            ushift_param_oport_sor,
  output logic [CNTW-1:0] ushift_param_oport_cnt,
  output logic            ushift_param_oport_done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_LOAD = 3'b101,
    M_CLR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SIZE - 1);

  logic [SIZE-1:0] p_q, p_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            counted;

  always_comb begin
    p_d     = p_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    counted = 1'b0;
    if (ushift_param_cport_en) begin
      case (mode_e'(ushift_param_cport_mode))
        M_SHL: begin
          p_d     = {p_q[SIZE-2:0], ushift_param_iport_sil};
          counted = 1'b1;
        end
        M_SHR: begin
          p_d     = {ushift_param_iport_sir, p_q[SIZE-1:1]};
          counted = 1'b1;
        end
        M_ROL: begin
          p_d     = {p_q[SIZE-2:0], p_q[SIZE-1]};
          counted = 1'b1;
        end
        M_ROR: begin
          p_d     = {p_q[0], p_q[SIZE-1:1]};
          counted = 1'b1;
        end
        M_LOAD: begin
          p_d   = ushift_param_ipport_pi;
          cnt_d = '0;
        end
        M_CLR: begin
          p_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // All four shift/rotate modes advance one shared frame counter.
    if (counted) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge ushift_param_cport_clk or negedge ushift_param_cport_rst) begin
    if (!ushift_param_cport_rst) begin
      p_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ushift_param_oport_p    = p_q;
  assign ushift_param_oport_sol  = p_q[SIZE-1];
  assign ushift_param_oport_sor  = p_q[0];
  assign ushift_param_oport_cnt  = cnt_q;
  assign ushift_param_oport_done = done_q;

endmodule

// File: tb/tb_ushift_param.sv
// Bench for ushift_param: an 8-bit main instance checked against a bit-queue model,
// plus 2-bit and 512-bit instances sharing the controls for counter/done sweeps.
module tb_ushift_param;

  localparam int S = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic         sil;
  logic         sir;
  logic [7:0]   pi8;
  logic [7:0]   p8;
  logic         sol8, sor8, done8;
  logic [3:0]   cnt8;
  logic [1:0]   pi2, p2, cnt2;
  logic         sol2, sor2, done2;
  logic [511:0] pi512, p512;
  logic [9:0]   cnt512;
  logic         sol512, sor512, done512;

  int checks = 0;
  int errors = 0;

  // Reference model: register as a bit queue (index 0 = LSB) and a running
  // count of counted operations since the last frame restart.
  bit mq[$];
  int m_total;
  bit m_counted;

  ushift_param #(.SIZE(8), .RST_VAL(8'hA5)) u8 (
    .ushift_param_cport_clk(clk), .ushift_param_cport_rst(rst_n),
    .ushift_param_cport_en(en), .ushift_param_cport_mode(mode),
    .ushift_param_iport_sil(sil), .ushift_param_iport_sir(sir),
    .ushift_param_ipport_pi(pi8), .ushift_param_oport_p(p8),
    .ushift_param_oport_sol(sol8), .ushift_param_oport_sor(sor8),
    .ushift_param_oport_cnt(cnt8), .ushift_param_oport_done(done8)
  );

  ushift_param #(.SIZE(2), .RST_VAL(2'b10)) u2 (
    .ushift_param_cport_clk(clk), .ushift_param_cport_rst(rst_n),
    .ushift_param_cport_en(en), .ushift_param_cport_mode(mode),
    .ushift_param_iport_sil(sil), .ushift_param_iport_sir(sir),
    .ushift_param_ipport_pi(pi2), .ushift_param_oport_p(p2),
    .ushift_param_oport_sol(sol2), .ushift_param_oport_sor(sor2),
    .ushift_param_oport_cnt(cnt2), .ushift_param_oport_done(done2)
  );

  ushift_param #(.SIZE(512)) u512 (
    .ushift_param_cport_clk(clk), .ushift_param_cport_rst(rst_n),
    .ushift_param_cport_en(en), .ushift_param_cport_mode(mode),
    .ushift_param_iport_sil(sil), .ushift_param_iport_sir(sir),
    .ushift_param_ipport_pi(pi512), .ushift_param_oport_p(p512),
    .ushift_param_oport_sol(sol512), .ushift_param_oport_sor(sor512),
    .ushift_param_oport_cnt(cnt512), .ushift_param_oport_done(done512)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [S-1:0] m_word();
    logic [S-1:0] r;
    for (int i = 0; i < S; i++) r[i] = mq[i];
    return r;
  endfunction

  task automatic model_reset();
    logic [7:0] rv;
    rv = 8'hA5;
    mq.delete();
    for (int i = 0; i < S; i++) mq.push_back(rv[i]);
    m_total   = 0;
    m_counted = 0;
  endtask

  task automatic model_apply();
    bit b;
    m_counted = 0;
    if (en) begin
      case (mode)
        3'b001: begin mq.push_front(sil); b = mq.pop_back(); m_counted = 1; end
        3'b010: begin b = mq.pop_front(); mq.push_back(sir); m_counted = 1; end
        3'b011: begin b = mq.pop_back(); mq.push_front(b); m_counted = 1; end
        3'b100: begin b = mq.pop_front(); mq.push_back(b); m_counted = 1; end
        3'b101: begin
          for (int i = 0; i < S; i++) mq[i] = pi8[i];
          m_total = 0;
        end
        3'b110: begin
          for (int i = 0; i < S; i++) mq[i] = 1'b0;
          m_total = 0;
        end
        default: ;
      endcase
    end
    if (m_counted) m_total++;
  endtask

  // Advance one clock: update the model from the current inputs, then sample
  // outputs 1ns after the rising edge.
  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 3'b000; sil = 0; sir = 0;
    pi8 = '0; pi2 = '0; pi512 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b1; mode = 3'b101; pi8 = 8'h00; pi2 = 2'b01;
    step();
    checks++;
    if (p8 !== 8'h00) begin errors++; $display("FAIL reset_preload p=%h exp 00", p8); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (p8 !== 8'hA5) begin errors++; $display("FAIL reset_p p=%h exp a5", p8); end
    checks++;
    if (cnt8 !== 4'd0 || done8 !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_done cnt=%0d done=%0b exp 0 0", cnt8, done8);
    end
    checks++;
    if (sol8 !== 1'b1 || sor8 !== 1'b1) begin
      errors++; $display("FAIL reset_taps sol=%0b sor=%0b exp 1 1", sol8, sor8);
    end
    checks++;
    if (p2 !== 2'b10 || cnt512 !== 10'd0 || p512 !== '0) begin
      errors++; $display("FAIL reset_others p2=%b cnt512=%0d", p2, cnt512);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_piso();
    int exp_sol[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    en = 1'b1; mode = 3'b101; pi8 = 8'h3C;
    step();
    checks++;
    if (p8 !== 8'h3C || cnt8 !== 4'd0) begin
      errors++; $display("FAIL piso_load p=%h cnt=%0d exp 3c 0", p8, cnt8);
    end
    mode = 3'b001; sil = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sol8 !== exp_sol[i][0]) begin
        errors++; $display("FAIL piso_sol i=%0d sol=%0b exp %0d", i, sol8, exp_sol[i]);
      end
      step();
      checks++;
      if (done8 !== (i == 7) || cnt8 !== 4'((i + 1) % 8)) begin
        errors++; $display("FAIL piso_cnt i=%0d done=%0b cnt=%0d", i, done8, cnt8);
      end
    end
    checks++;
    if (p8 !== 8'h00) begin errors++; $display("FAIL piso_end p=%h exp 00", p8); end
    mode = 3'b000;
    step();
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL piso_done_width done=%0b exp 0", done8); end
  endtask

  task automatic test_sipo();
    int seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int pulses = 0;
    mode = 3'b110;
    step();
    mode = 3'b010;
    for (int i = 0; i < 8; i++) begin
      sir = seq[i][0];
      step();
      if (done8) pulses++;
      checks++;
      if (cnt8 !== 4'((i + 1) % 8) || done8 !== (i == 7)) begin
        errors++; $display("FAIL sipo_cnt i=%0d cnt=%0d done=%0b", i, cnt8, done8);
      end
    end
    checks++;
    if (p8 !== 8'h4D || p8 !== m_word()) begin
      errors++; $display("FAIL sipo_word p=%h exp 4d", p8);
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL sipo_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_rotate();
    mode = 3'b101; pi8 = 8'h81;
    step();
    mode = 3'b011;
    repeat (3) step();
    checks++;
    if (p8 !== 8'h0C || cnt8 !== 4'd3) begin
      errors++; $display("FAIL rot_left p=%h cnt=%0d exp 0c 3", p8, cnt8);
    end
    en = 1'b0; mode = 3'b100;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (p8 !== 8'h0C || cnt8 !== 4'd3 || done8 !== 1'b0) begin
        errors++; $display("FAIL rot_hold i=%0d p=%h cnt=%0d done=%0b", i, p8, cnt8, done8);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (done8 !== (i == 4)) begin
        errors++; $display("FAIL rot_done i=%0d done=%0b exp %0b", i, done8, (i == 4));
      end
    end
    checks++;
    if (p8 !== 8'h60 || cnt8 !== 4'd0) begin
      errors++; $display("FAIL rot_right p=%h cnt=%0d exp 60 0", p8, cnt8);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    mode = 3'b001;
    repeat (5) begin sil = 1'($urandom_range(0, 1)); step(); end
    mode = 3'b110;
    step();
    checks++;
    if (p8 !== 8'h00 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      errors++; $display("FAIL abort_clear p=%h cnt=%0d done=%0b", p8, cnt8, done8);
    end
    mode = 3'b001;
    repeat (6) begin sil = 1'($urandom_range(0, 1)); step(); end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (p8 !== 8'hA5 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      errors++; $display("FAIL abort_reset p=%h cnt=%0d done=%0b", p8, cnt8, done8);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sil = 1'($urandom_range(0, 1));
      step();
      if (done8) pulses++;
      checks++;
      if (done8 !== (i == 7) || p8 !== m_word()) begin
        errors++; $display("FAIL abort_frame i=%0d done=%0b p=%h exp %h", i, done8, p8, m_word());
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_random();
    logic [7:0] w;
    for (int i = 0; i < 300; i++) begin
      en    = ($urandom_range(0, 5) != 0);
      mode  = 3'($urandom_range(0, 7));
      sil   = 1'($urandom_range(0, 1));
      sir   = 1'($urandom_range(0, 1));
      pi8   = 8'($urandom);
      pi2   = 2'($urandom);
      pi512 = {16{$urandom}};
      step();
      w = m_word();
      checks++;
      if (p8 !== w || sol8 !== w[7] || sor8 !== w[0]) begin
        errors++; $display("FAIL rand_p i=%0d p=%h sol=%0b sor=%0b exp %h", i, p8, sol8, sor8, w);
      end
      checks++;
      if (cnt8 !== 4'(m_total % 8) || done8 !== (m_counted && (m_total % 8 == 0))) begin
        errors++; $display("FAIL rand_cnt8 i=%0d cnt=%0d done=%0b exp %0d", i, cnt8, done8, m_total % 8);
      end
      checks++;
      if (cnt2 !== 2'(m_total % 2) || done2 !== (m_counted && (m_total % 2 == 0))) begin
        errors++; $display("FAIL rand_cnt2 i=%0d cnt=%0d done=%0b exp %0d", i, cnt2, done2, m_total % 2);
      end
      checks++;
      if (cnt512 !== 10'(m_total % 512) || done512 !== (m_counted && (m_total % 512 == 0))) begin
        errors++; $display("FAIL rand_cnt512 i=%0d cnt=%0d done=%0b exp %0d", i, cnt512, done512, m_total % 512);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] held;
    bit hist[$];
    en = 1'b1; mode = 3'b110;
    step();
    mode = 3'b001;
    repeat (3) begin sil = 1'($urandom_range(0, 1)); step(); end
    held = m_word();
    mode = 3'b111;
    repeat (2) step();
    mode = 3'b000;
    step();
    checks++;
    if (p8 !== held || cnt8 !== 4'd3 || cnt2 !== 2'd1 || done8 !== 1'b0) begin
      errors++; $display("FAIL hold_rsvd p=%h cnt=%0d cnt2=%0d exp %h 3 1", p8, cnt8, cnt2, held);
    end
    mode = 3'b110;
    step();
    mode = 3'b001;
    for (int k = 1; k <= 1024; k++) begin
      sil = 1'($urandom_range(0, 1));
      hist.push_back(sil);
      step();
      checks++;
      if (k <= 16 && done8 !== (k == 8 || k == 16)) begin
        errors++; $display("FAIL sweep8_first k=%0d done=%0b", k, done8);
      end else if (done8 !== (k % 8 == 0) || cnt8 !== 4'(k % 8)) begin
        errors++; $display("FAIL sweep8 k=%0d done=%0b cnt=%0d", k, done8, cnt8);
      end
      checks++;
      if (done2 !== (k % 2 == 0) || cnt2 !== 2'(k % 2)) begin
        errors++; $display("FAIL sweep2 k=%0d done=%0b cnt=%0d", k, done2, cnt2);
      end
      checks++;
      if (done512 !== (k % 512 == 0) || cnt512 !== 10'(k % 512)) begin
        errors++; $display("FAIL sweep512 k=%0d done=%0b cnt=%0d", k, done512, cnt512);
      end
    end
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (p512[i] !== hist[hist.size() - 1 - i]) begin
        errors++; $display("FAIL sweep512_word bit=%0d got %0b exp %0b", i, p512[i], hist[hist.size() - 1 - i]);
      end
    end
    checks++;
    if (sol512 !== hist[hist.size() - 512] || sor512 !== hist[hist.size() - 1]) begin
      errors++; $display("FAIL sweep512_taps sol=%0b sor=%0b", sol512, sor512);
    end
    checks++;
    if (p2 !== {hist[hist.size() - 2], hist[hist.size() - 1]} ||
        sol2 !== hist[hist.size() - 2] || sor2 !== hist[hist.size() - 1]) begin
      errors++; $display("FAIL sweep2_word p=%b sol=%0b sor=%0b", p2, sol2, sor2);
    end
  endtask

  initial begin
    test_reset();
    test_piso();
    test_sipo();
    test_rotate();
    test_abort();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
